// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the iCache/dCache main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned LINE_W_DEF = 128;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    // Round-robin pick: a lone requester wins; on conflict the one not granted last wins.
    function automatic arb_req_t pick_winner(input logic     req_i,
                                             input logic     req_d,
                                             input arb_req_t last);
        arb_req_t win;
        win = REQ_I;
        if (req_i && req_d) begin
            win = (last == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            win = REQ_D;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full = (r_count == {W{1'b1}});

    // Count up on i_inc until every bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory line port between iCache and dCache, one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned CACHE_LINE_SIZE = LINE_W_DEF,
    parameter int unsigned ADDR_WIDTH      = ADDR_W_DEF,
    parameter int unsigned CNT_WIDTH       = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_i_read_en,
    input  logic                       in_i_write_en,
    input  logic [ADDR_WIDTH-1:0]      in_i_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_i_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
    output logic                       out_i_ready,
    input  logic                       in_d_read_en,
    input  logic                       in_d_write_en,
    input  logic [ADDR_WIDTH-1:0]      in_d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
    output logic                       out_d_ready,
    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [ADDR_WIDTH-1:0]      out_mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
    input  logic                       in_mem_ready,
    output logic                       out_busy,
    output logic [CNT_WIDTH-1:0]       out_i_wait_cycles,
    output logic [CNT_WIDTH-1:0]       out_d_wait_cycles
);

    arb_state_t                 r_state;
    arb_req_t                   r_last_grant;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [CACHE_LINE_SIZE-1:0] r_wdata;
    logic                       r_mem_read_en;
    logic                       r_mem_write_en;

    logic                       w_req_i;
    logic                       w_req_d;
    logic                       w_idle;
    arb_req_t                   w_winner;
    logic                       w_grant_i;
    logic                       w_grant_d;
    logic                       w_sel_write;
    logic [ADDR_WIDTH-1:0]      w_sel_addr;
    logic [CACHE_LINE_SIZE-1:0] w_sel_wdata;
    logic                       w_inc_i;
    logic                       w_inc_d;

    // Request decode and grant selection; grants are only issued from IDLE.
    assign w_req_i   = in_i_read_en | in_i_write_en;
    assign w_req_d   = in_d_read_en | in_d_write_en;
    assign w_idle    = (r_state == ARB_IDLE);
    assign w_winner  = pick_winner(w_req_i, w_req_d, r_last_grant);
    assign w_grant_i = w_idle & w_req_i & (w_winner == REQ_I);
    assign w_grant_d = w_idle & w_req_d & (w_winner == REQ_D);

    // Steer the winner's request into the latch; read+write together counts as a write.
    assign w_sel_write = (w_winner == REQ_D) ? in_d_write_en   : in_i_write_en;
    assign w_sel_addr  = (w_winner == REQ_D) ? in_d_addr       : in_i_addr;
    assign w_sel_wdata = (w_winner == REQ_D) ? in_d_write_data : in_i_write_data;

    // Arbiter FSM: latch the granted request, hold the strobe until memory completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ARB_IDLE;
            r_last_grant   <= REQ_I;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_state        <= w_grant_d ? ARB_SERVE_D : ARB_SERVE_I;
                        r_last_grant   <= w_winner;
                        r_addr         <= w_sel_addr;
                        r_wdata        <= w_sel_wdata;
                        r_mem_write_en <= w_sel_write;
                        r_mem_read_en  <= ~w_sel_write;
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (in_mem_ready) begin
                        r_state        <= ARB_IDLE;
                        r_mem_read_en  <= 1'b0;
                        r_mem_write_en <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ARB_IDLE;
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                end
            endcase
        end
    end

    // Completion is forwarded in the same cycle memory reports it, only to the granted cache.
    assign out_i_ready     = (r_state == ARB_SERVE_I) & in_mem_ready;
    assign out_d_ready     = (r_state == ARB_SERVE_D) & in_mem_ready;
    assign out_i_read_data = in_mem_read_data;
    assign out_d_read_data = in_mem_read_data;

    assign out_mem_read_en    = r_mem_read_en;
    assign out_mem_write_en   = r_mem_write_en;
    assign out_mem_addr       = r_addr;
    assign out_mem_write_data = r_wdata;
    assign out_busy           = ~w_idle;

    // A requester waits in any cycle it asks, is not being served, and is not granted now.
    assign w_inc_i = w_req_i & (r_state != ARB_SERVE_I) & ~w_grant_i;
    assign w_inc_d = w_req_d & (r_state != ARB_SERVE_D) & ~w_grant_d;

    sat_counter #(.W(CNT_WIDTH)) u_i_wait (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc_i),
        .o_count (out_i_wait_cycles)
    );

    sat_counter #(.W(CNT_WIDTH)) u_d_wait (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc_d),
        .o_count (out_d_wait_cycles)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; a second instance with 3-bit counters shares the stimulus.
module tb_mem_arbiter;

    localparam int unsigned LW = 128;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_i_read_en, in_i_write_en, in_d_read_en, in_d_write_en;
    logic [AW-1:0] in_i_addr, in_d_addr;
    logic [LW-1:0] in_i_write_data, in_d_write_data, in_mem_read_data;
    logic          in_mem_ready;

    logic [LW-1:0] out_i_read_data, out_d_read_data, out_mem_write_data;
    logic          out_i_ready, out_d_ready, out_mem_read_en, out_mem_write_en, out_busy;
    logic [AW-1:0] out_mem_addr;
    logic [31:0]   out_i_wait_cycles, out_d_wait_cycles;

    logic [LW-1:0] s_i_read_data, s_d_read_data, s_mem_write_data;
    logic          s_i_ready, s_d_ready, s_mem_read_en, s_mem_write_en, s_busy;
    logic [AW-1:0] s_mem_addr;
    logic [2:0]    s_i_wait_cycles, s_d_wait_cycles;

    mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset),
        .in_i_read_en(in_i_read_en), .in_i_write_en(in_i_write_en),
        .in_i_addr(in_i_addr), .in_i_write_data(in_i_write_data),
        .out_i_read_data(out_i_read_data), .out_i_ready(out_i_ready),
        .in_d_read_en(in_d_read_en), .in_d_write_en(in_d_write_en),
        .in_d_addr(in_d_addr), .in_d_write_data(in_d_write_data),
        .out_d_read_data(out_d_read_data), .out_d_ready(out_d_ready),
        .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
        .out_mem_addr(out_mem_addr), .out_mem_write_data(out_mem_write_data),
        .in_mem_read_data(in_mem_read_data), .in_mem_ready(in_mem_ready),
        .out_busy(out_busy),
        .out_i_wait_cycles(out_i_wait_cycles), .out_d_wait_cycles(out_d_wait_cycles)
    );

    mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .reset(reset),
        .in_i_read_en(in_i_read_en), .in_i_write_en(in_i_write_en),
        .in_i_addr(in_i_addr), .in_i_write_data(in_i_write_data),
        .out_i_read_data(s_i_read_data), .out_i_ready(s_i_ready),
        .in_d_read_en(in_d_read_en), .in_d_write_en(in_d_write_en),
        .in_d_addr(in_d_addr), .in_d_write_data(in_d_write_data),
        .out_d_read_data(s_d_read_data), .out_d_ready(s_d_ready),
        .out_mem_read_en(s_mem_read_en), .out_mem_write_en(s_mem_write_en),
        .out_mem_addr(s_mem_addr), .out_mem_write_data(s_mem_write_data),
        .in_mem_read_data(in_mem_read_data), .in_mem_ready(in_mem_ready),
        .out_busy(s_busy),
        .out_i_wait_cycles(s_i_wait_cycles), .out_d_wait_cycles(s_d_wait_cycles)
    );

    typedef struct {
        logic          who;   // 0 = iCache, 1 = dCache
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned exp_i_wait = 0;
    int unsigned exp_d_wait = 0;
    int          gap;

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        return {32'hDEADBEEF, a, ~a, 32'hCAFEF00D};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_waits(input string tag);
        chk({tag, "_i_wait"}, LW'(out_i_wait_cycles), LW'(exp_i_wait));
        chk({tag, "_d_wait"}, LW'(out_d_wait_cycles), LW'(exp_d_wait));
        chk({tag, "_sat_i_wait"}, LW'(s_i_wait_cycles), LW'(exp_i_wait > 7 ? 7 : exp_i_wait));
        chk({tag, "_sat_d_wait"}, LW'(s_d_wait_cycles), LW'(exp_d_wait > 7 ? 7 : exp_d_wait));
    endtask

    // Drive a request and record its expected memory transaction in grant order.
    task automatic push(input logic who, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [LW-1:0] d);
        txn_t e;
        e.who = who; e.wr = wr; e.addr = a; e.wdata = d;
        sb.push_back(e);
        if (who) begin
            in_d_read_en = rd; in_d_write_en = wr; in_d_addr = a; in_d_write_data = d;
        end else begin
            in_i_read_en = rd; in_i_write_en = wr; in_i_addr = a; in_i_write_data = d;
        end
    endtask

    task automatic drop(input logic who);
        if (who) begin
            in_d_read_en = 1'b0; in_d_write_en = 1'b0;
        end else begin
            in_i_read_en = 1'b0; in_i_write_en = 1'b0;
        end
    endtask

    // Act as memory for the next scoreboard entry: completes after lat strobe cycles.
    task automatic serve(input int lat, output int gap_o);
        txn_t          e;
        int            n;
        logic [LW-1:0] rd;
        logic [1:0]    rdy_exp;
        gap_o = -1;
        if (sb.size() == 0) begin
            chk("sb_empty", LW'(1), LW'(0));
            return;
        end
        e = sb.pop_front();
        rdy_exp = e.who ? 2'b01 : 2'b10;
        n = 0;
        @(negedge clk);
        while (!(out_mem_read_en | out_mem_write_en) && n < 32) begin
            @(negedge clk);
            n++;
        end
        gap_o = n;
        chk("strobe_seen", LW'(n < 32), LW'(1'b1));
        chk("mem_addr", LW'(out_mem_addr), LW'(e.addr));
        chk("mem_op", LW'({out_mem_read_en, out_mem_write_en}), LW'({~e.wr, e.wr}));
        chk("busy", LW'(out_busy), LW'(1'b1));
        chk("sat_mem", LW'({s_mem_read_en, s_mem_write_en, s_busy, s_mem_addr}),
            LW'({~e.wr, e.wr, 1'b1, e.addr}));
        if (e.wr) begin
            chk("mem_wdata", out_mem_write_data, e.wdata);
            chk("sat_wdata", s_mem_write_data, e.wdata);
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("strobe_held", LW'({out_mem_read_en, out_mem_write_en}), LW'({~e.wr, e.wr}));
            chk("no_early_ready", LW'({out_i_ready, out_d_ready}), LW'(2'b00));
        end
        rd = mem_line(e.addr);
        in_mem_read_data = rd;
        in_mem_ready     = 1'b1;
        #1;
        chk("ready", LW'({out_i_ready, out_d_ready}), LW'(rdy_exp));
        chk("sat_ready", LW'({s_i_ready, s_d_ready}), LW'(rdy_exp));
        if (!e.wr) begin
            if (e.who) begin
                chk("d_rdata", out_d_read_data, rd);
                chk("sat_d_rdata", s_d_read_data, rd);
            end else begin
                chk("i_rdata", out_i_read_data, rd);
                chk("sat_i_rdata", s_i_read_data, rd);
            end
        end
        step();
        in_mem_ready = 1'b0;
        drop(e.who);
        @(negedge clk);
        chk("strobe_drop", LW'({out_mem_read_en, out_mem_write_en}), LW'(2'b00));
        chk("turnaround_idle", LW'(out_busy), LW'(1'b0));
        chk("ready_drop", LW'({out_i_ready, out_d_ready}), LW'(2'b00));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        in_i_read_en = 1'b0; in_i_write_en = 1'b0; in_i_addr = '0; in_i_write_data = '0;
        in_d_read_en = 1'b0; in_d_write_en = 1'b0; in_d_addr = '0; in_d_write_data = '0;
        in_mem_read_data = '0; in_mem_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_strobes", LW'({out_mem_read_en, out_mem_write_en}), LW'(2'b00));
        chk("rst_busy", LW'(out_busy), LW'(1'b0));
        chk("rst_ready", LW'({out_i_ready, out_d_ready}), LW'(2'b00));
        chk("rst_addr", LW'(out_mem_addr), LW'(0));
        chk("rst_wdata", out_mem_write_data, LW'(0));
        chk_waits("rst");

        // 1: lone iCache read, memory completes after three strobe cycles.
        step();
        push(1'b0, 1'b1, 1'b0, 32'h100, '0);
        serve(3, gap);
        chk("t1_grant_latency", LW'(gap), LW'(1));
        chk_waits("t1");

        // 2: simultaneous requests after reset; dCache wins, iCache follows after one idle cycle.
        step();
        push(1'b1, 1'b0, 1'b1, 32'h80, {4{32'hA5A5_0080}});
        push(1'b0, 1'b1, 1'b0, 32'h40, '0);
        serve(2, gap);
        serve(2, gap);
        chk("t2_turnaround", LW'(gap), LW'(0));
        exp_i_wait += 3;
        chk_waits("t2");

        // 3: repeated conflicts keep alternating D then I.
        for (int r = 0; r < 2; r++) begin
            step();
            push(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(r * 16), '0);
            push(1'b0, 1'b0, 1'b1, 32'h2000 + 32'(r * 16), {4{32'h1234_0000 + 32'(r)}});
            serve(r == 0 ? 1 : 4, gap);
            serve(r == 0 ? 1 : 2, gap);
            chk("t3_turnaround", LW'(gap), LW'(0));
            exp_i_wait += (r == 0) ? 2 : 5;
            chk_waits("t3");
        end

        // 4: dCache read+write together is issued as a write.
        step();
        push(1'b1, 1'b1, 1'b1, 32'h200, {4{32'h0BAD_F00D}});
        serve(1, gap);
        chk_waits("t4");

        // 4b: after a D grant, the next conflict goes to I.
        step();
        push(1'b0, 1'b1, 1'b0, 32'h300, '0);
        push(1'b1, 1'b1, 1'b0, 32'h340, '0);
        serve(2, gap);
        serve(1, gap);
        exp_d_wait += 3;
        chk_waits("t4b");

        // 5: reset during an iCache transaction abandons it.
        step();
        in_i_read_en = 1'b1;
        in_i_addr    = 32'h500;
        n = 0;
        @(negedge clk);
        while (!out_mem_read_en && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk("t5_strobe_seen", LW'(n < 32), LW'(1'b1));
        step();
        reset = 1'b1;
        drop(1'b0);
        step();
        reset = 1'b0;
        in_mem_read_data = mem_line(32'h500);
        in_mem_ready = 1'b1;
        @(negedge clk);
        chk("t5_strobes", LW'({out_mem_read_en, out_mem_write_en}), LW'(2'b00));
        chk("t5_busy", LW'(out_busy), LW'(1'b0));
        chk("t5_no_ready", LW'({out_i_ready, out_d_ready, s_i_ready, s_d_ready}), LW'(4'b0000));
        exp_i_wait = 0;
        exp_d_wait = 0;
        chk_waits("t5");
        step();
        in_mem_ready = 1'b0;
        push(1'b1, 1'b1, 1'b0, 32'h600, '0);
        serve(2, gap);
        chk_waits("t5_after");

        // 6: stray memory completion while idle, then a long wait saturating the 3-bit counter.
        step();
        in_mem_read_data = mem_line(32'hFFFF);
        in_mem_ready = 1'b1;
        @(negedge clk);
        chk("t6_stray_ready", LW'({out_i_ready, out_d_ready, s_i_ready, s_d_ready}), LW'(4'b0000));
        chk("t6_stray_busy", LW'({out_busy, out_mem_read_en, out_mem_write_en}), LW'(3'b000));
        step();
        in_mem_ready = 1'b0;
        push(1'b0, 1'b1, 1'b0, 32'h700, '0);
        push(1'b1, 1'b1, 1'b0, 32'h740, '0);
        serve(10, gap);
        serve(1, gap);
        exp_d_wait += 11;
        chk_waits("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
